// File: rtl/darkmemctl_if.sv
// darkmemctl_if: request/response bundle between the darkpablomem scheduler
// port (master) and the darkmemctl data memory (slave).
//   PAB_VALID/RD/WR/ADDR/DATA/BE : request from the scheduler
//   MEM_READY/VALID/DATA         : handshake and read response from memory
interface darkmemctl_if;
  logic        PAB_VALID;
  logic        PAB_RD;
  logic        PAB_WR;
  logic [31:0] PAB_ADDR;
  logic [31:0] PAB_DATA;
  logic [3:0]  PAB_BE;
  logic        MEM_READY;
  logic        MEM_VALID;
  logic [31:0] MEM_DATA;

  modport master (
    output PAB_VALID, PAB_RD, PAB_WR, PAB_ADDR, PAB_DATA, PAB_BE,
    input  MEM_READY, MEM_VALID, MEM_DATA
  );

  modport slave (
    input  PAB_VALID, PAB_RD, PAB_WR, PAB_ADDR, PAB_DATA, PAB_BE,
    output MEM_READY, MEM_VALID, MEM_DATA
  );
endinterface

// File: rtl/darkmemctl.sv
// darkmemctl: word-addressed synchronous data memory for the shared request
// port of darkpablomem. One request at a time over READY/VALID; the access
// happens LATENCY edges after acceptance and a one-cycle MEM_VALID follows.
// Addresses with bit 31 set form the IO window: writes dropped, reads give 0.
// Ports:
//   XCLK  : clock, rising edge
//   XRES  : asynchronous active-high reset
//   bus   : darkmemctl_if.slave (PAB_* request in, MEM_* response out)
module darkmemctl #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 3
) (
  input  logic         XCLK,
  input  logic         XRES,
  darkmemctl_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;

  // Latched request; only the word index and IO-window bit of the address matter.
  logic [AW-1:0]  req_idx_p0;
  logic           req_io_p0;
  logic           req_rd_p0;
  logic           req_wr_p0;
  logic [31:0]    req_data_p0;
  logic [3:0]     req_be_p0;

  logic [31:0]    mem [DEPTH];

  logic           accept;
  logic           access;

  // Address bits outside the word index are deliberately ignored (wrap).
  logic           unused_addr;
  assign unused_addr = ^{bus.PAB_ADDR[30:AW+2], bus.PAB_ADDR[1:0]};

  // MEM_READY is registered, so acceptance never depends combinationally on
  // anything but the request valid.
  assign accept = bus.PAB_VALID && bus.MEM_READY;
  // The access edge is the one leaving WAIT with the counter exhausted.
  assign access = (state == WAIT) && (cnt == '0);

  // ---- stage 0: request capture at acceptance ----
  always_ff @(posedge XCLK) begin
    if (accept) begin
      req_idx_p0  <= bus.PAB_ADDR[AW+1:2];
      req_io_p0   <= bus.PAB_ADDR[31];
      req_rd_p0   <= bus.PAB_RD;
      req_wr_p0   <= bus.PAB_WR;
      req_data_p0 <= bus.PAB_DATA;
      req_be_p0   <= bus.PAB_BE;
    end
  end

  // ---- stage 1: array access on the RESP-entry edge ----
  // Reset forces state to IDLE asynchronously, so an aborted request never
  // reaches this edge and its write is discarded.
  always_ff @(posedge XCLK) begin
    if (access && req_wr_p0 && !req_io_p0) begin
      for (int b = 0; b < 4; b++) begin
        if (req_be_p0[b]) begin
          mem[req_idx_p0][8*b +: 8] <= req_data_p0[8*b +: 8];
        end
      end
    end
  end

  // Control FSM with registered handshake outputs. The read samples the array
  // before the same-edge write lands, giving read-before-write for RD+WR.
  always_ff @(posedge XCLK or posedge XRES) begin
    if (XRES) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.MEM_READY <= 1'b1;
      bus.MEM_VALID <= 1'b0;
      bus.MEM_DATA  <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          bus.MEM_VALID <= 1'b0;
          if (accept) begin
            state         <= WAIT;
            cnt           <= CW'(LATENCY - 1);
            bus.MEM_READY <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state         <= RESP;
            bus.MEM_VALID <= 1'b1;
            bus.MEM_READY <= 1'b1;
            if (req_rd_p0) begin
              bus.MEM_DATA <= req_io_p0 ? 32'h0 : mem[req_idx_p0];
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          bus.MEM_VALID <= 1'b0;
          if (accept) begin
            state         <= WAIT;
            cnt           <= CW'(LATENCY - 1);
            bus.MEM_READY <= 1'b0;
          end else begin
            state         <= IDLE;
            bus.MEM_READY <= 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          bus.MEM_READY <= 1'b1;
          bus.MEM_VALID <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_darkmemctl.sv
// tb_darkmemctl: scoreboard bench for darkmemctl. Accepted requests are
// queued with their due cycle; each MEM_VALID pops one entry, and a
// reference memory model computes the expected MEM_DATA.
module tb_darkmemctl;

  localparam int DEPTH   = 1024;
  localparam int LATENCY = 3;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    int          due;
  } req_t;

  logic XCLK;
  logic XRES;

  darkmemctl_if bus ();

  darkmemctl #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .XCLK (XCLK),
    .XRES (XRES),
    .bus  (bus)
  );

  int          n_chk  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  int          rdy_low = 0;
  int          vcount = 0;
  int          vcyc[$];
  req_t        sb[$];
  logic [31:0] model [DEPTH];
  logic [31:0] last_rd;

  initial XCLK = 1'b0;
  always #5 XCLK = ~XCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Acceptance monitor: values sampled here are the pre-edge ones.
  always @(posedge XCLK) begin
    req_t e;
    cyc = cyc + 1;
    if (!XRES && bus.PAB_VALID && bus.MEM_READY) begin
      e.rd   = bus.PAB_RD;
      e.wr   = bus.PAB_WR;
      e.addr = bus.PAB_ADDR;
      e.data = bus.PAB_DATA;
      e.be   = bus.PAB_BE;
      e.due  = cyc + LATENCY;
      sb.push_back(e);
    end
  end

  // Response monitor: the reference model is updated in response order.
  always @(negedge XCLK) begin
    req_t        e;
    logic [31:0] exp;
    int unsigned wi;
    if (!XRES && !bus.MEM_READY) rdy_low++;
    if (!XRES && bus.MEM_VALID) begin
      vcount++;
      vcyc.push_back(cyc);
      if (sb.size() == 0) begin
        chk("stray_valid", 32'd1, 32'd0);
      end else begin
        e  = sb.pop_front();
        wi = (e.addr[30:0] >> 2) % DEPTH;
        if (e.rd) begin
          exp     = e.addr[31] ? 32'h0 : model[wi];
          last_rd = exp;
        end else begin
          exp = last_rd;
        end
        chk("rdata", bus.MEM_DATA, exp);
        chk("latency", cyc, e.due);
        if (e.wr && !e.addr[31]) begin
          for (int b = 0; b < 4; b++)
            if (e.be[b]) model[wi][8*b +: 8] = e.data[8*b +: 8];
        end
      end
    end
  end

  task automatic drop();
    bus.PAB_VALID = 1'b0;
    bus.PAB_RD    = 1'b0;
    bus.PAB_WR    = 1'b0;
  endtask

  // Present a request and return #1 after the edge that accepts it.
  task automatic req(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] data, input logic [3:0] be);
    bus.PAB_VALID = 1'b1;
    bus.PAB_RD    = rd;
    bus.PAB_WR    = wr;
    bus.PAB_ADDR  = addr;
    bus.PAB_DATA  = data;
    bus.PAB_BE    = be;
    for (int i = 0; i < 50; i++) begin
      @(negedge XCLK);
      if (bus.MEM_READY) begin
        @(posedge XCLK);
        #1;
        return;
      end
    end
    chk("accept_timeout", 32'd0, 32'd1);
    drop();
  endtask

  task automatic wait_done();
    drop();
    for (int i = 0; i < 100; i++) begin
      @(negedge XCLK);
      if (sb.size() == 0) break;
    end
    chk("drain", sb.size(), 32'd0);
    repeat (2) @(posedge XCLK);
    #1;
  endtask

  initial begin
    int rl0;
    int v0;
    int n0;
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    last_rd       = 32'h0;
    XRES          = 1'b1;
    bus.PAB_ADDR  = 32'h0;
    bus.PAB_DATA  = 32'h0;
    bus.PAB_BE    = 4'h0;
    drop();
    repeat (3) @(posedge XCLK);
    #1 XRES = 1'b0;
    chk("rst_ready", bus.MEM_READY, 32'd1);
    chk("rst_valid", bus.MEM_VALID, 32'd0);
    chk("rst_data",  bus.MEM_DATA,  32'h0);

    // Latency and handshake
    rl0 = rdy_low;
    v0  = vcount;
    req(1'b0, 1'b1, 32'h10, 32'h12345678, 4'hF);
    wait_done();
    chk("ready_low_cycles", rdy_low - rl0, 32'd3);
    chk("valid_pulses", vcount - v0, 32'd1);
    req(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    wait_done();
    chk("read_0x10", bus.MEM_DATA, 32'h12345678);

    // Reset mid-WAIT of a write to word 5
    req(1'b0, 1'b1, 32'h14, 32'hDEADBEEF, 4'hF);
    drop();
    @(posedge XCLK);
    #2;
    XRES = 1'b1;
    sb.delete();
    last_rd = 32'h0;
    #1;
    chk("async_rst_ready", bus.MEM_READY, 32'd1);
    chk("async_rst_valid", bus.MEM_VALID, 32'd0);
    chk("async_rst_data",  bus.MEM_DATA,  32'h0);
    v0 = vcount;
    repeat (3) @(posedge XCLK);
    #1 XRES = 1'b0;
    repeat (6) @(posedge XCLK);
    #1;
    chk("no_valid_after_rst", vcount - v0, 32'd0);
    req(1'b1, 1'b0, 32'h14, 32'h0, 4'h0);
    wait_done();

    // Byte enables
    req(1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'hF);
    req(1'b0, 1'b1, 32'h20, 32'h11223344, 4'b0101);
    req(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    wait_done();
    chk("be_merge", bus.MEM_DATA, 32'hAA22CC44);
    req(1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0);
    req(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    wait_done();

    // No-op request: MEM_DATA holds
    req(1'b0, 1'b0, 32'h20, 32'h0, 4'hF);
    wait_done();

    // IO window and wrap
    req(1'b0, 1'b1, 32'h8000_0010, 32'hCAFEF00D, 4'hF);
    req(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    req(1'b1, 1'b0, 32'h8000_0010, 32'h0, 4'h0);
    wait_done();
    chk("io_read_zero", bus.MEM_DATA, 32'h0);
    req(1'b0, 1'b1, 32'h0000_1004, 32'h0A0B0C0D, 4'hF);
    req(1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
    wait_done();

    // Back-to-back alternating write/read to 0x30
    n0  = vcyc.size();
    rl0 = rdy_low;
    req(1'b0, 1'b1, 32'h30, 32'h55AA0001, 4'hF);
    req(1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
    req(1'b0, 1'b1, 32'h30, 32'h0BADF00D, 4'hF);
    req(1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
    wait_done();
    chk("b2b_pulses", vcyc.size() - n0, 32'd4);
    chk("b2b_ready_low", rdy_low - rl0, 32'd12);
    for (int i = 1; i < 4; i++)
      chk("b2b_gap", vcyc[n0+i] - vcyc[n0+i-1], 32'd4);

    // Simultaneous RD+WR
    req(1'b0, 1'b1, 32'h40, 32'h1, 4'hF);
    req(1'b1, 1'b1, 32'h40, 32'h2, 4'hF);
    wait_done();
    chk("rdwr_old", bus.MEM_DATA, 32'h1);
    req(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    wait_done();
    chk("rdwr_new", bus.MEM_DATA, 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/darkmemctl.md
# darkmemctl

Word-addressed synchronous data memory serving the single shared request port of the `darkpablomem` scheduler in `darkdpgroup`. It replaces the inline fake memory. It accepts one request at a time through a READY/VALID handshake and applies byte-enabled writes. After a parameterised access latency it returns read data. Addresses with bit 31 set form the IO window: writes there are suppressed and reads return zero.

## Interface
- `DEPTH`, 1024: number of 32-bit words; power of two, ≥2; `AW = $clog2(DEPTH)`.
- `LATENCY`, 3: cycles from request acceptance to response; integer ≥1.

- `XCLK`  in  1  sole clock, rising edge.
- `XRES`  in  1  reset, asynchronous, active-high.
- `PAB_VALID`  in  1  request present.
- `PAB_RD`  in  1  read request qualifier.
- `PAB_WR`  in  1  write request qualifier.
- `PAB_ADDR`  in  32  byte address; bits [AW+1:2] index the word.
- `PAB_DATA`  in  32  write data.
- `PAB_BE`  in  4  byte enables; bit n selects PAB_DATA[8n+7:8n].
- `MEM_READY`  out  1  controller can accept a request this cycle.
- `MEM_VALID`  out  1  one-cycle response strobe.
- `MEM_DATA`  out  32  read data; valid while MEM_VALID=1 after a read, then held.

## Operation
- A request is accepted at a rising edge where PAB_VALID=1 and MEM_READY=1.
  - At acceptance, PAB_ADDR, PAB_DATA, PAB_BE, PAB_RD and PAB_WR are latched into request registers.
  - Inputs are ignored after acceptance.
- The FSM has three states: IDLE, WAIT and RESP.
  - IDLE: MEM_READY=1, MEM_VALID=0. On acceptance, go to WAIT and load `cnt = LATENCY-1`.
  - WAIT: MEM_READY=0, MEM_VALID=0. At each edge, if cnt==0 go to RESP, else decrement cnt. The access is performed on the edge that enters RESP, using the latched request.
  - RESP: MEM_VALID=1 and MEM_READY=1 for exactly one cycle. On acceptance in this cycle, go to WAIT and reload cnt (back-to-back requests). Otherwise go to IDLE.
- The access is decoded from the latched request:
  - Word index is addr[AW+1:2]. Bits [1:0] are ignored. Bits [30:AW+2] are ignored, so accesses wrap modulo DEPTH.
  - Write (wr=1, addr[31]=0): update each byte whose BE bit is set; other bytes are unchanged. BE=4'b0000 writes nothing.
  - Write with addr[31]=1: no memory change; a response is still issued.
  - Read (rd=1): MEM_DATA takes the memory word, or 32'h0 if addr[31]=1.
  - Read and write together: MEM_DATA returns the pre-write word (read-before-write), and the write is applied.
  - Neither rd nor wr: no-op, and MEM_VALID is still issued.
  - MEM_DATA changes only on read completion; it holds its value across writes and idle cycles.
- Memory array contents are not reset; the simulation model initialises them to 0.

## Timing
- Reset values: state=IDLE, MEM_READY=1, MEM_VALID=0, MEM_DATA=32'h0, cnt=0.
- Reset mid-operation:
  - A latched request is discarded, and no write occurs if reset asserts before the RESP-entry edge.
  - No MEM_VALID follows. MEM_READY=1 immediately on assertion, since reset is asynchronous.
- Latency:
  - Acceptance at edge E0 gives MEM_VALID=1 in the cycle following edge E0+LATENCY.
  - MEM_READY is 0 for exactly LATENCY cycles per request.
  - With LATENCY=1, the WAIT state lasts one cycle.
- Throughput with back-to-back requests: one request per LATENCY+1 cycles.
- Read-after-write across requests: a read accepted in the RESP cycle of a write observes the written data.
- MEM_VALID is never high for two consecutive cycles unless LATENCY... it never is: minimum spacing is LATENCY+1 ≥ 2.
- MEM_READY and MEM_VALID are registered; there is no combinational path from PAB_* to any output.

## Test plan
- **Reset:** assert XRES for 3 cycles mid-WAIT of a write to word 5 (data 32'hDEADBEEF). Then MEM_READY=1, MEM_VALID=0 and MEM_DATA=0 asynchronously. Word 5 reads back 0 and no stray MEM_VALID appears.
- **Latency and handshake:** LATENCY=3, write 32'h12345678 at 0x10, BE=4'hF.
  - MEM_READY is low for exactly 3 cycles.
  - MEM_VALID pulses 1 cycle at E0+3.
  - A read of 0x10 then returns 32'h12345678 with MEM_VALID.
- **Byte enables:** preload 0x20=32'hAABBCCDD, write 32'h11223344 with BE=4'b0101. A read returns 32'hAA22CC44. A write with BE=0 leaves it unchanged.
- **IO window and wrap:**
  - A write to 32'h8000_0010 leaves word 4 unchanged. A read of 32'h8000_0010 returns 0 with MEM_VALID.
  - With DEPTH=1024, a write to 32'h0000_1004 aliases to word 1 (0x4).
- **Back-to-back:** hold PAB_VALID=1 across 4 alternating write/read requests to 0x30. Each request is accepted in the RESP cycle of the previous one. MEM_VALID pulses every 4 cycles (LATENCY=3). Each read returns the preceding write's data.
- **Simultaneous RD+WR:** word 0x40=32'h1, request rd=wr=1 with data 32'h2. MEM_DATA returns 32'h1; a subsequent read returns 32'h2.
